// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: read/write/reserve requests
// in, read data, pending bits and collision flag out.
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] R1;
    logic [ADDR_W-1:0] R2;
    logic              WE1;
    logic [ADDR_W-1:0] W1;
    logic [DATA_W-1:0] D1;
    logic              WE2;
    logic [ADDR_W-1:0] W2;
    logic [DATA_W-1:0] D2;
    logic              RSV;
    logic [ADDR_W-1:0] RSV_A;
    logic [DATA_W-1:0] Out1;
    logic [DATA_W-1:0] Out2;
    logic              Pend1;
    logic              Pend2;
    logic              Conflict;

    modport master (
        output R1, R2, WE1, W1, D1, WE2, W2, D2, RSV, RSV_A,
        input  Out1, Out2, Pend1, Pend2, Conflict
    );

    modport slave (
        input  R1, R2, WE1, W1, D1, WE2, W2, D2, RSV, RSV_A,
        output Out1, Out2, Pend1, Pend2, Conflict
    );
endinterface

// File: rtl/reg_file_mp.sv
// Two-read / two-write register file with port-2 write priority, optional
// zero register and bypass, and per-register pending bits for hazard checks.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_mp_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  pend_reg;
    logic              conflict_reg;

    logic              we1_eff;
    logic              we2_eff;
    logic              rsv_eff;
    logic [DEPTH-1:0]  wsel1;
    logic [DEPTH-1:0]  wsel2;
    logic [DEPTH-1:0]  rsel;

    // Address 0 is made unwritable/unreservable here so no later logic needs to care.
    assign we1_eff = bus.WE1 && !(ZERO_REG != 0 && bus.W1 == '0);
    assign we2_eff = bus.WE2 && !(ZERO_REG != 0 && bus.W2 == '0);
    assign rsv_eff = bus.RSV && !(ZERO_REG != 0 && bus.RSV_A == '0);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign wsel1[gi] = we1_eff && (bus.W1 == ADDR_W'(gi));
            assign wsel2[gi] = we2_eff && (bus.W2 == ADDR_W'(gi));
            assign rsel[gi]  = rsv_eff && (bus.RSV_A == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            pend_reg     <= '0;
            conflict_reg <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wsel2[i]) begin
                    regs_reg[i] <= bus.D2;
                end else if (wsel1[i]) begin
                    regs_reg[i] <= bus.D1;
                end
                // A reserve issued alongside the retiring write is a newer producer.
                if (rsel[i]) begin
                    pend_reg[i] <= 1'b1;
                end else if (wsel1[i] || wsel2[i]) begin
                    pend_reg[i] <= 1'b0;
                end
            end
            conflict_reg <= bus.WE1 && bus.WE2 && (bus.W1 == bus.W2);
        end
    end

    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] data;
        data = regs_reg[addr];
        if (BYPASS != 0) begin
            if (we2_eff && bus.W2 == addr) begin
                data = bus.D2;
            end else if (we1_eff && bus.W1 == addr) begin
                data = bus.D1;
            end
        end
        if (!rst || (ZERO_REG != 0 && addr == '0)) begin
            data = '0;
        end
        return data;
    endfunction

    assign bus.Out1     = read_data(bus.R1);
    assign bus.Out2     = read_data(bus.R2);
    assign bus.Pend1    = pend_reg[bus.R1];
    assign bus.Pend2    = pend_reg[bus.R2];
    assign bus.Conflict = conflict_reg;
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file for the MIPS datapath, successor to the single-write 32x32 file. It provides two asynchronous read ports and two write ports with a fixed priority on write collisions. It also has an optional hardwired zero register, optional write-to-read bypass, and per-register pending bits that track outstanding writes for hazard detection in the pipeline.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/reserves
BYPASS, 1, 1 = same-cycle write data forwarded to read outputs

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
R1  in  ADDR_W  read address, port 1
R2  in  ADDR_W  read address, port 2
WE1  in  1  write enable, port 1
W1  in  ADDR_W  write address, port 1
D1  in  DATA_W  write data, port 1
WE2  in  1  write enable, port 2
W2  in  ADDR_W  write address, port 2
D2  in  DATA_W  write data, port 2
RSV  in  1  reserve strobe: mark register RSV_A pending
RSV_A  in  ADDR_W  register to reserve
Out1  out  DATA_W  read data, port 1
Out2  out  DATA_W  read data, port 2
Pend1  out  1  pending bit of register R1
Pend2  out  1  pending bit of register R2
Conflict  out  1  registered flag: WE1 & WE2 & (W1==W2) seen last cycle

Behaviour:
- Reset (rst=0, async): all registers = 0, all pending bits = 0, Conflict = 0. While in reset, Out1/Out2 = 0 and Pend1/Pend2 = 0.
- Write: on posedge clk, if WEn then reg[Wn] <= Dn. Both ports may write in one cycle.
- Collision (WE1 & WE2 & W1==W2): port 2 wins; reg gets D2. Conflict goes 1 for the following cycle, otherwise 0.
- Read: combinational, zero-cycle latency: Outk = reg[Rk].
- Bypass (BYPASS=1): if WE2 & W2==Rk then Outk = D2; else if WE1 & W1==Rk then Outk = D1; else reg[Rk]. This is the same priority as the write.
- BYPASS=0: Outk shows the new value the cycle after the write edge.
- ZERO_REG=1: writes and reserves to address 0 are ignored. Out=0 and Pend=0 whenever Rk==0, including under bypass.
- Pending bits, evaluated on posedge clk:
  - A write to address A (either port) clears pend[A].
  - RSV sets pend[RSV_A].
  - If RSV and a write target the same address in the same cycle, set wins and pend stays 1 (a new producer was issued).
  - Pendk = pend[Rk], registered state only; it is not bypassed.
- Address width rules: addresses are unsigned and index the full 2**ADDR_W depth. There is no out-of-range case.
- Reset asserted mid-operation: clears state immediately, regardless of clk. Writes and reserves in the same cycle as reset deassertion take effect at the next posedge.

Test Plan:
- Reset, then write D1=32 to reg 1 (WE1=1) and D2=25 to reg 3 (WE2=1) in the same cycle, with R1=1, R2=3 → with BYPASS=1, Out1=32 and Out2=25 in that cycle; after the edge, with WE cleared, Out1=32 and Out2=25.
- Collision: WE1=WE2=1, W1=W2=7, D1=0xAAAA, D2=0x5555, R1=7 → bypass Out1=0x5555; reg7=0x5555 after the edge; Conflict=1 for exactly one cycle.
- Zero register: write 0xFFFFFFFF to reg 0 via both ports, RSV_A=0, R1=0 → Out1=0, Pend1=0 in every cycle.
- Pending: RSV=1, RSV_A=9 → Pend1 (R1=9) becomes 1 after the edge. Later WE1=1, W1=9 → Pend1 returns to 0 after the edge. Same-cycle RSV_A=9 with W2=9 → Pend1 stays 1.
- Async reset: write 0x1234 to reg 5, then pull rst low between clock edges → Out1 (R1=5) reads 0 immediately and Pend bits read 0. After release, reg5 reads 0 until it is rewritten.
- BYPASS=0 instance: write 100 to reg 4 with R1=4 → Out1 shows old value 0 during the write cycle and 100 after the edge.
